jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Controller and arbiter for a bank of JK-style storage bits shared between two requesters (A and B). Each requester issues a JK command (hold/clear/set/toggle) with a bit mask and a repeat count. The block arbitrates round-robin and then drives the bank's J/K inputs for the requested number of cycles. It sits between control logic and the flip-flop bank, and is the only writer of the bank.

## Interface
- WIDTH, 8: number of bank bits.
- REP_W, 4: width of the repeat-count field.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- a_valid / b_valid  in  1  requester has a command pending.
- a_ready / b_ready  out  1  command accepted on this edge when valid && ready.
- a_op / b_op  in  2  JK code {J,K}: 00 hold, 01 clear, 10 set, 11 toggle.
- a_mask / b_mask  in  WIDTH  bits affected by the command.
- a_reps / b_reps  in  REP_W  number of extra applications; total applications = reps+1.
- a_done / b_done  out  1  one-cycle pulse when that requester's command completes.
- busy  out  1  high while a command is executing (state RUN).
- grant_b  out  1  owner of the current or most recent command: 0 = A, 1 = B.
- q  out  WIDTH  bank state.
- q_n  out  WIDTH  bitwise inverse of q, combinational.

## Operation
- States: IDLE and RUN.
- IDLE
  - a_ready = a_valid && (!b_valid || last == B).
  - b_ready = b_valid && (!a_valid || last == A).
  - Both ready outputs are combinational from the valids and `last`; at most one is high.
- Acceptance edge
  - Capture op, mask and reps from the winner into registers.
  - Set last and grant_b to the winner; go to RUN.
  - The bank does not change on the acceptance edge.
- RUN
  - Every edge applies the captured op to the bank. For masked bits: j = op[1], k = op[0]. Unmasked bits get j = k = 0.
  - Per-bit next state: 00 → q, 01 → 0, 10 → 1, 11 → ~q.
  - The counter starts at reps and decrements per application.
  - On the application edge where the counter equals 0, return to IDLE and register done for the owner.
- In RUN, both readys are 0. Requesters must hold valid and their payload stable until ready.
- done_x is high in the first IDLE cycle. A new command can be accepted in that same cycle, so back-to-back commands are allowed.
- mask = 0 or op = 00 still takes reps+1 cycles and pulses done; q is unchanged.
- Arbitration
  - Round-robin on simultaneous valids: the requester not granted last wins.
  - A lone requester always wins, regardless of last.

## Timing
- Reset values: q = 0, q_n = all ones, state IDLE, busy = 0, a_done = b_done = 0, grant_b = 1, last = B (A wins the first tie).
- Latency: valid and ready seen at edge E0; first q change visible after E1; final application at E(reps+1).
- done is high during cycle E(reps+1)..E(reps+2). busy is high from E0 until E(reps+1).
- Occupancy: reps+1 cycles in RUN per command. Peak throughput is one command per reps+2 cycles.
- Reset asserted mid-RUN: the command is abandoned and no done pulse is issued. All outputs take their reset values on that edge.
- Reset overrides valid on the same edge: no acceptance.
- Counter wrap: reps = all ones gives 2^REP_W applications. The counter never underflows.

## Structure
- Package jk_ctrl_pkg holds:
  - enum jk_op_t: JK_HOLD = 2'b00, JK_CLR = 2'b01, JK_SET = 2'b10, JK_TGL = 2'b11.
  - enum ctrl_state_t: IDLE, RUN.
  - Requester id constants: REQ_A = 0, REQ_B = 1.
- Sub-module jk_bank holds WIDTH JK bits with vector j/k inputs, synchronous active-low reset to 0, and q/q_n outputs.
- The top level contains the arbiter, capture registers, counter and FSM. It drives jk_bank's j/k vectors.

## Test plan
- Reset, then A: op = 10, mask = 8'h0F, reps = 0. Expect a_ready at E0, q = 8'h0F after E1, a_done one cycle, busy high for 1 cycle.
- From q = 8'h0F, B: op = 11, mask = 8'hFF, reps = 2. Expect q = F0, 0F, F0 on successive edges, b_done after the third application, grant_b = 1.
- a_valid and b_valid held together for 4 commands, each op 00 with reps 0. Expect grants in order A, B, A, B, with no gap beyond one IDLE cycle between commands.
- B valid during A's reps = 5 run. Expect b_ready low throughout RUN; B is accepted in the cycle a_done is high; q unchanged by B's op 00.
- rst_n low at the second application of A's toggle, reps = 3. Expect q = 0, no a_done, busy = 0 next cycle, and A wins the next tie.
- reps = 4'hF with op 11, mask 8'h01. Expect 16 toggles, final q[0] equal to its initial value, one done pulse.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK bank controller.
// Op codes, FSM states and requester ids.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // J inputs for a command: masked bits take op[1]
    function automatic logic [7:0] jk_j8(jk_op_t op, logic [7:0] mask);
        return op[1] ? mask : 8'h00;
    endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with vector J/K inputs.
// Synchronous active-low reset clears every bit.
module jk_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    // Per-bit JK update: 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

    assign q_n = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter and sequencer driving a JK bank.
// Two requesters share the bank; one command runs at a time.
module jk_bank_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_mask,
    input  logic [REP_W-1:0] a_reps,
    output logic             a_done,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_mask,
    input  logic [REP_W-1:0] b_reps,
    output logic             b_done,
    output logic             busy,
    output logic             grant_b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    localparam logic [REP_W-1:0] CNT_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    ctrl_state_t      state;
    logic             last;
    jk_op_t           op_r;
    logic [WIDTH-1:0] mask_r;
    logic [REP_W-1:0] cnt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    // The requester not served last wins a tie; a lone one always wins
    assign a_ready = (state == IDLE) && a_valid
                     && (!b_valid || last == REQ_B);
    assign b_ready = (state == IDLE) && b_valid
                     && (!a_valid || last == REQ_A);

    assign busy    = (state == RUN);
    assign grant_b = last;

    // Drive J/K only while running; unmasked bits hold
    always_comb begin
        j = '0;
        k = '0;
        if (state == RUN) begin
            j = op_r[1] ? mask_r : '0;
            k = op_r[0] ? mask_r : '0;
        end
    end

    // Controller FSM: capture on accept, count applications, pulse done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            last   <= REQ_B;
            op_r   <= JK_HOLD;
            mask_r <= '0;
            cnt    <= '0;
            a_done <= 1'b0;
            b_done <= 1'b0;
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a_ready) begin
                        op_r   <= jk_op_t'(a_op);
                        mask_r <= a_mask;
                        cnt    <= a_reps;
                        last   <= REQ_A;
                        state  <= RUN;
                    end else if (b_ready) begin
                        op_r   <= jk_op_t'(b_op);
                        mask_r <= b_mask;
                        cnt    <= b_reps;
                        last   <= REQ_B;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        a_done <= (last == REQ_A);
                        b_done <= (last == REQ_B);
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    jk_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .j    (j),
        .k    (k),
        .q    (q),
        .q_n  (q_n)
    );

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter.
// Directed scenarios then random traffic against a command-level model.
module tb_jk_bank_arbiter;

    localparam int WIDTH = 8;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             a_valid, b_valid;
    logic             a_ready, b_ready;
    logic [1:0]       a_op, b_op;
    logic [WIDTH-1:0] a_mask, b_mask;
    logic [REP_W-1:0] a_reps, b_reps;
    logic             a_done, b_done;
    logic             busy, grant_b;
    logic [WIDTH-1:0] q, q_n;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_q;
    bit         m_last;
    bit         m_run;
    int         m_left;
    bit         m_owner;
    logic [1:0] m_op;
    logic [7:0] m_mask;
    bit         m_da, m_db;
    bit         m_known = 0;
    int         a_left = 0;
    int         b_left = 0;
    bit         acc_a, acc_b;

    always #5 clk = ~clk;

    jk_bank_arbiter #(
        .WIDTH(WIDTH),
        .REP_W(REP_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_op   (a_op),
        .a_mask (a_mask),
        .a_reps (a_reps),
        .a_done (a_done),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_op   (b_op),
        .b_mask (b_mask),
        .b_reps (b_reps),
        .b_done (b_done),
        .busy   (busy),
        .grant_b(grant_b),
        .q      (q),
        .q_n    (q_n)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] apply(logic [1:0] op, logic [7:0] v,
                                         logic [7:0] mask);
        case (op)
            2'b01:   return v & ~mask;
            2'b10:   return v | mask;
            2'b11:   return v ^ mask;
            default: return v;
        endcase
    endfunction

    // one clock: check readies, advance model, check outputs
    task automatic step();
        bit         ea, eb;
        logic [7:0] m_qn;
        #1;
        ea = !m_run && a_valid && (!b_valid || m_last);
        eb = !m_run && b_valid && (!a_valid || !m_last);
        if (m_known) begin
            chk("a_ready", {31'd0, a_ready}, {31'd0, ea});
            chk("b_ready", {31'd0, b_ready}, {31'd0, eb});
        end
        @(posedge clk);
        acc_a = 0;
        acc_b = 0;
        if (!rst_n) begin
            m_q = 8'h00; m_last = 1; m_run = 0; m_left = 0;
            m_da = 0; m_db = 0; m_known = 1;
        end else begin
            m_da = 0;
            m_db = 0;
            if (m_run) begin
                m_q = apply(m_op, m_q, m_mask);
                m_left--;
                if (m_left == 0) begin
                    m_run = 0;
                    if (m_owner) m_db = 1;
                    else m_da = 1;
                end
            end else if (ea) begin
                acc_a = 1; m_owner = 0; m_last = 0; m_run = 1;
                m_op = a_op; m_mask = a_mask; m_left = int'(a_reps) + 1;
            end else if (eb) begin
                acc_b = 1; m_owner = 1; m_last = 1; m_run = 1;
                m_op = b_op; m_mask = b_mask; m_left = int'(b_reps) + 1;
            end
        end
        #1;
        if (m_known) begin
            m_qn = ~m_q;
            chk("q", {24'd0, q}, {24'd0, m_q});
            chk("q_n", {24'd0, q_n}, {24'd0, m_qn});
            chk("busy", {31'd0, busy}, {31'd0, m_run});
            chk("grant_b", {31'd0, grant_b}, {31'd0, m_last});
            chk("a_done", {31'd0, a_done}, {31'd0, m_da});
            chk("b_done", {31'd0, b_done}, {31'd0, m_db});
        end
        @(negedge clk);
        if (acc_a) begin
            a_left--;
            if (a_left <= 0) a_valid = 0;
        end
        if (acc_b) begin
            b_left--;
            if (b_left <= 0) b_valid = 0;
        end
    endtask

    task automatic issue_a(logic [1:0] op, logic [7:0] mask,
                           logic [3:0] reps, int n);
        a_op = op; a_mask = mask; a_reps = reps; a_valid = 1; a_left = n;
    endtask

    task automatic issue_b(logic [1:0] op, logic [7:0] mask,
                           logic [3:0] reps, int n);
        b_op = op; b_mask = mask; b_reps = reps; b_valid = 1; b_left = n;
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int   order[$];
        int   stamp[$];
        logic prev_done;
        int   pulses;
        int   flips;
        logic q0;

        rst_n = 0;
        a_valid = 0; a_op = 0; a_mask = 0; a_reps = 0;
        b_valid = 0; b_op = 0; b_mask = 0; b_reps = 0;
        step();
        step();
        rst_n = 1;
        step();
        chk("reset_q", {24'd0, q}, 32'h00);
        chk("reset_q_n", {24'd0, q_n}, 32'hFF);
        chk("reset_grant_b", {31'd0, grant_b}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // A sets low nibble once
        issue_a(2'b10, 8'h0F, 4'd0, 1);
        step();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("t1_q", {24'd0, q}, 32'h0F);
        chk("t1_done", {31'd0, a_done}, 32'd1);
        chk("t1_busy_off", {31'd0, busy}, 32'd0);
        step();
        chk("t1_done_once", {31'd0, a_done}, 32'd0);

        // B toggles all bits three times
        issue_b(2'b11, 8'hFF, 4'd2, 1);
        step();
        step();
        chk("t2_q1", {24'd0, q}, 32'hF0);
        step();
        chk("t2_q2", {24'd0, q}, 32'h0F);
        step();
        chk("t2_q3", {24'd0, q}, 32'hF0);
        chk("t2_done", {31'd0, b_done}, 32'd1);
        chk("t2_grant_b", {31'd0, grant_b}, 32'd1);
        step();

        // both requesters held together: strict alternation
        issue_a(2'b00, 8'h33, 4'd0, 2);
        issue_b(2'b00, 8'hCC, 4'd0, 2);
        for (int i = 0; i < 12; i++) begin
            step();
            if (acc_a) begin order.push_back(0); stamp.push_back(i); end
            if (acc_b) begin order.push_back(1); stamp.push_back(i); end
        end
        chk("t3_count", order.size(), 32'd4);
        if (order.size() == 4) begin
            chk("t3_g0", order[0], 32'd0);
            chk("t3_g1", order[1], 32'd1);
            chk("t3_g2", order[2], 32'd0);
            chk("t3_g3", order[3], 32'd1);
            for (int i = 1; i < 4; i++)
                chk("t3_gap", stamp[i] - stamp[i-1], 32'd2);
        end
        chk("t3_q", {24'd0, q}, 32'hF0);

        // B waits out A's long run, accepted alongside a_done
        issue_a(2'b01, 8'hAA, 4'd5, 1);
        step();
        issue_b(2'b00, 8'hFF, 4'd0, 1);
        for (int i = 0; i < 20; i++) begin
            prev_done = a_done;
            step();
            if (acc_b) begin
                chk("t4_acc_with_done", {31'd0, prev_done}, 32'd1);
                break;
            end
        end
        drain(3);
        chk("t4_q", {24'd0, q}, 32'h50);

        // reset lands on the second application of a toggle
        issue_a(2'b11, 8'hFF, 4'd3, 1);
        step();
        step();
        chk("t5_q_first", {24'd0, q}, 32'hAF);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("t5_q_reset", {24'd0, q}, 32'h00);
        chk("t5_no_done", {31'd0, a_done}, 32'd0);
        step();
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_no_done2", {31'd0, a_done}, 32'd0);
        issue_a(2'b00, 8'h00, 4'd0, 1);
        issue_b(2'b00, 8'h00, 4'd0, 1);
        step();
        chk("t5_tie_grant", {31'd0, grant_b}, 32'd0);
        drain(5);

        // full counter wrap: sixteen toggles of bit 0
        q0 = q[0];
        pulses = 0;
        flips = 0;
        issue_a(2'b11, 8'h01, 4'hF, 1);
        for (int i = 0; i < 20; i++) begin
            prev_done = q[0];
            step();
            if (q[0] !== prev_done) flips++;
            if (a_done) pulses++;
        end
        chk("t6_pulses", pulses, 32'd1);
        chk("t6_flips", flips, 32'd16);
        chk("t6_q0", {31'd0, q[0]}, {31'd0, q0});

        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if (!a_valid && $urandom_range(0, 2) == 0)
                issue_a(2'($urandom), 8'($urandom),
                        ($urandom_range(0, 9) == 0) ? 4'hF
                                                    : 4'($urandom_range(0, 3)),
                        1);
            if (!b_valid && $urandom_range(0, 2) == 0)
                issue_b(2'($urandom), 8'($urandom),
                        ($urandom_range(0, 9) == 0) ? 4'hF
                                                    : 4'($urandom_range(0, 3)),
                        1);
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        rst_n = 1;
        a_valid = 0;
        b_valid = 0;
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
